// File: rtl/counter_bank.sv
// counter_bank
//   Bank of NUM_CNT independent up/down counters on one clock. Each lane has
//   its own enable, direction and parallel load, and either wraps modulo
//   2^WIDTH (SAT=0) or sticks at 0 / 2^WIDTH-1 (SAT=1). A registered
//   terminal-count pulse per lane flags a wrap, or a step blocked at a limit.
//   A registered sum of all lanes follows the counters one cycle behind.
//
// Ports
//   clk     rising-edge clock
//   rst     asynchronous active-high reset (cnt, tc and sum forced to 0)
//   clr     synchronous clear of every lane (priority over ld and en)
//   en      per-lane count enable
//   up      per-lane direction, 1 = increment, 0 = decrement
//   ld      per-lane parallel load strobe (priority over en)
//   ld_val  load values, lane i in [i*WIDTH +: WIDTH]
//   cnt     counter values, lane i in [i*WIDTH +: WIDTH]
//   tc      per-lane terminal-count pulse, aligned with the cnt it describes
//   sum     zero-extended sum of all lanes as they stood one cycle earlier
module counter_bank #(
  parameter int WIDTH   = 16,
  parameter int NUM_CNT = 4,
  parameter int SAT     = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                clr,
  input  logic [NUM_CNT-1:0]                  en,
  input  logic [NUM_CNT-1:0]                  up,
  input  logic [NUM_CNT-1:0]                  ld,
  input  logic [NUM_CNT*WIDTH-1:0]            ld_val,
  output logic [NUM_CNT*WIDTH-1:0]            cnt,
  output logic [NUM_CNT-1:0]                  tc,
  output logic [WIDTH+$clog2(NUM_CNT)-1:0]    sum
);

  localparam int SUM_W = WIDTH + $clog2(NUM_CNT);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  // Result of one counting step: new value plus the terminal-count flag.
  typedef struct packed {
    logic             tc;
    logic [WIDTH-1:0] val;
  } step_t;

  // Increment with wrap or saturation at the top of the range.
  function automatic step_t step_up(input logic [WIDTH-1:0] v);
    step_t r;
    if (v == CNT_MAX) begin
      r.tc  = 1'b1;
      r.val = (SAT != 0) ? CNT_MAX : '0;
    end else begin
      r.tc  = 1'b0;
      r.val = v + 1'b1;
    end
    return r;
  endfunction

  // Decrement with wrap or saturation at the bottom of the range.
  function automatic step_t step_dn(input logic [WIDTH-1:0] v);
    step_t r;
    if (v == '0) begin
      r.tc  = 1'b1;
      r.val = (SAT != 0) ? '0 : CNT_MAX;
    end else begin
      r.tc  = 1'b0;
      r.val = v - 1'b1;
    end
    return r;
  endfunction

  // Packed 2-D views line lane i up with bits [i*WIDTH +: WIDTH].
  logic [NUM_CNT-1:0][WIDTH-1:0] ld_lane;
  logic [NUM_CNT-1:0][WIDTH-1:0] cnt_nxt;
  logic [NUM_CNT-1:0][WIDTH-1:0] cnt_p0;
  logic [NUM_CNT-1:0]            tc_nxt;
  logic [NUM_CNT-1:0]            tc_p0;
  logic [SUM_W-1:0]              sum_nxt;
  logic [SUM_W-1:0]              sum_p1;

  assign ld_lane = ld_val;

  // Stage p0: per-lane next value, priority clr > ld > en.
  always_comb begin
    step_t s;
    s       = '0;
    cnt_nxt = cnt_p0;
    tc_nxt  = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (clr) begin
        cnt_nxt[i] = '0;
      end else if (ld[i]) begin
        cnt_nxt[i] = ld_lane[i];
      end else if (en[i]) begin
        s          = up[i] ? step_up(cnt_p0[i]) : step_dn(cnt_p0[i]);
        cnt_nxt[i] = s.val;
        tc_nxt[i]  = s.tc;
      end
    end
  end

  // Stage p1: sum of the registered lanes. Growth bits make it exact.
  always_comb begin
    sum_nxt = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      sum_nxt = sum_nxt + SUM_W'(cnt_p0[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_p0 <= '0;
      tc_p0  <= '0;
      sum_p1 <= '0;
    end else begin
      cnt_p0 <= cnt_nxt;
      tc_p0  <= tc_nxt;
      sum_p1 <= sum_nxt;
    end
  end

  assign cnt = cnt_p0;
  assign tc  = tc_p0;
  assign sum = sum_p1;

endmodule

// File: tb/tb_counter_bank.sv
// tb_counter_bank
//   Three instances share one stimulus stream: WIDTH=4 with two wrapping
//   lanes (a), two saturating lanes (b), and four wrapping lanes (c).
//   Expected outputs come from an integer reference model and are queued per
//   clock edge (or reset assertion); a monitor pops and compares them.
module tb_counter_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic [3:0]  en = '0, up = '0, ld = '0;
  logic [15:0] ld_val = '0;

  logic [7:0]  cnt_a, cnt_b;
  logic [15:0] cnt_c;
  logic [1:0]  tc_a, tc_b;
  logic [3:0]  tc_c;
  logic [4:0]  sum_a, sum_b;
  logic [5:0]  sum_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  counter_bank #(.WIDTH(4), .NUM_CNT(2), .SAT(0)) u_a (
    .clk(clk), .rst(rst), .clr(clr), .en(en[1:0]), .up(up[1:0]), .ld(ld[1:0]),
    .ld_val(ld_val[7:0]), .cnt(cnt_a), .tc(tc_a), .sum(sum_a));

  counter_bank #(.WIDTH(4), .NUM_CNT(2), .SAT(1)) u_b (
    .clk(clk), .rst(rst), .clr(clr), .en(en[1:0]), .up(up[1:0]), .ld(ld[1:0]),
    .ld_val(ld_val[7:0]), .cnt(cnt_b), .tc(tc_b), .sum(sum_b));

  counter_bank #(.WIDTH(4), .NUM_CNT(4), .SAT(0)) u_c (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .up(up), .ld(ld),
    .ld_val(ld_val), .cnt(cnt_c), .tc(tc_c), .sum(sum_c));

  typedef struct packed {
    logic [7:0]  cnt_a;
    logic [7:0]  cnt_b;
    logic [15:0] cnt_c;
    logic [1:0]  tc_a;
    logic [1:0]  tc_b;
    logic [3:0]  tc_c;
    logic [4:0]  sum_a;
    logic [4:0]  sum_b;
    logic [5:0]  sum_c;
  } exp_t;

  exp_t q[$];

  // Reference model: plain integers, one row per instance.
  int mcnt[3][4];
  int mtc[3][4];
  int msum[3];

  function automatic int nlanes(input int d);
    return (d == 2) ? 4 : 2;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      msum[d] = 0;
      for (int b = 0; b < 4; b++) begin
        mcnt[d][b] = 0;
        mtc[d][b]  = 0;
      end
    end
  endtask

  task automatic model_step(input logic c, input logic [3:0] e, input logic [3:0] u,
                            input logic [3:0] l, input logic [15:0] lv);
    int s, n;
    for (int d = 0; d < 3; d++) begin
      s = 0;
      for (int b = 0; b < nlanes(d); b++) s += mcnt[d][b];
      msum[d] = s;
      for (int b = 0; b < nlanes(d); b++) begin
        mtc[d][b] = 0;
        if (c) begin
          mcnt[d][b] = 0;
        end else if (l[b]) begin
          mcnt[d][b] = int'(lv[b*4 +: 4]);
        end else if (e[b]) begin
          n = mcnt[d][b] + (u[b] ? 1 : -1);
          if (n < 0 || n > 15) begin
            mtc[d][b] = 1;
            if (d != 1) mcnt[d][b] = n & 15;
          end else begin
            mcnt[d][b] = n;
          end
        end
      end
    end
  endtask

  function automatic exp_t pack_exp();
    exp_t x;
    x = '0;
    for (int b = 0; b < 2; b++) begin
      x.cnt_a[b*4 +: 4] = 4'(mcnt[0][b]);
      x.cnt_b[b*4 +: 4] = 4'(mcnt[1][b]);
      x.tc_a[b]         = 1'(mtc[0][b]);
      x.tc_b[b]         = 1'(mtc[1][b]);
    end
    for (int b = 0; b < 4; b++) begin
      x.cnt_c[b*4 +: 4] = 4'(mcnt[2][b]);
      x.tc_c[b]         = 1'(mtc[2][b]);
    end
    x.sum_a = 5'(msum[0]);
    x.sum_b = 5'(msum[1]);
    x.sum_c = 6'(msum[2]);
    return x;
  endfunction

  // Called at a negedge: drive inputs for the coming posedge, queue the
  // expected result, and return at the following negedge.
  task automatic cycle(input logic c, input logic [3:0] e, input logic [3:0] u,
                       input logic [3:0] l, input logic [15:0] lv);
    rst = 1'b0; clr = c; en = e; up = u; ld = l; ld_val = lv;
    model_step(c, e, u, l, lv);
    q.push_back(pack_exp());
    @(negedge clk);
  endtask

  // Called at a negedge: raise rst away from any clock edge, expect zeros
  // immediately, then hold it for n posedges.
  task automatic do_reset(input int n);
    #2;
    en = '0; up = '0; ld = '0; clr = 1'b0;
    model_reset();
    q.push_back(pack_exp());
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      q.push_back(pack_exp());
      @(negedge clk);
    end
  endtask

  // Monitor: one expectation per posedge clk or rst assertion.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk or posedge rst);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("cnt_a", 32'(cnt_a), 32'(x.cnt_a));
        chk("cnt_b", 32'(cnt_b), 32'(x.cnt_b));
        chk("cnt_c", 32'(cnt_c), 32'(x.cnt_c));
        chk("tc_a",  32'(tc_a),  32'(x.tc_a));
        chk("tc_b",  32'(tc_b),  32'(x.tc_b));
        chk("tc_c",  32'(tc_c),  32'(x.tc_c));
        chk("sum_a", 32'(sum_a), 32'(x.sum_a));
        chk("sum_b", 32'(sum_b), 32'(x.sum_b));
        chk("sum_c", 32'(sum_c), 32'(x.sum_c));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        c;
    logic [3:0]  e, u, l;
    logic [15:0] lv;
    logic        bias;
    model_reset();
    @(negedge clk);
    do_reset(2);
    chk("init_rst_cnt", 32'(cnt_c), 32'd0);

    // Reset mid-count, then resume from zero.
    cycle(0, 4'b0000, 4'b0000, 4'b0001, 16'h0007);
    chk("ld7_cnt0", 32'(cnt_a[3:0]), 32'd7);
    do_reset(1);
    chk("rst_cnt0", 32'(cnt_a[3:0]), 32'd0);
    chk("rst_sum",  32'(sum_a), 32'd0);
    cycle(0, 4'b0001, 4'b0001, 4'b0000, 16'h0000);
    chk("resume_cnt0", 32'(cnt_a[3:0]), 32'd1);

    // Upward boundary: wrap on a, saturate on b.
    cycle(0, 4'b0000, 4'b0000, 4'b0001, 16'h000E);
    cycle(0, 4'b0001, 4'b0001, 4'b0000, 16'h0000);
    chk("up15_tc_a", 32'(tc_a[0]), 32'd0);
    chk("up15_tc_b", 32'(tc_b[0]), 32'd0);
    cycle(0, 4'b0001, 4'b0001, 4'b0000, 16'h0000);
    chk("wrap_cnt_a", 32'(cnt_a[3:0]), 32'd0);
    chk("wrap_tc_a",  32'(tc_a[0]),    32'd1);
    chk("sat_cnt_b",  32'(cnt_b[3:0]), 32'd15);
    chk("sat_tc_b",   32'(tc_b[0]),    32'd1);
    cycle(0, 4'b0001, 4'b0001, 4'b0000, 16'h0000);
    chk("after_wrap_cnt_a", 32'(cnt_a[3:0]), 32'd1);
    chk("after_wrap_tc_a",  32'(tc_a[0]),    32'd0);
    chk("sat_again_tc_b",   32'(tc_b[0]),    32'd1);

    // Downward boundary from 0.
    cycle(0, 4'b0000, 4'b0000, 4'b0001, 16'h0000);
    cycle(0, 4'b0001, 4'b0000, 4'b0000, 16'h0000);
    chk("dn_wrap_cnt_a", 32'(cnt_a[3:0]), 32'd15);
    chk("dn_wrap_tc_a",  32'(tc_a[0]),    32'd1);
    chk("dn_sat_cnt_b",  32'(cnt_b[3:0]), 32'd0);
    chk("dn_sat_tc_b",   32'(tc_b[0]),    32'd1);

    // Priority: clr beats ld and en; ld beats en.
    cycle(1, 4'b0010, 4'b0010, 4'b0001, 16'h0009);
    chk("clr_prio_cnt_a", 32'(cnt_a), 32'd0);
    cycle(0, 4'b0001, 4'b0001, 4'b0001, 16'h0009);
    chk("ld_prio_cnt0", 32'(cnt_a[3:0]), 32'd9);
    chk("ld_prio_tc",   32'(tc_a),       32'd0);

    // All lanes at MAX: sum needs the growth bits.
    cycle(0, 4'b0000, 4'b0000, 4'b1111, 16'hFFFF);
    chk("ld_max_tc_c", 32'(tc_c), 32'd0);
    cycle(0, 4'b0000, 4'b0000, 4'b0000, 16'h0000);
    chk("sum30_a", 32'(sum_a), 32'd30);
    chk("sum30_b", 32'(sum_b), 32'd30);
    chk("sum60_c", 32'(sum_c), 32'd60);

    // Randomised traffic; the up/down bias flips periodically so lanes
    // reach both limits often.
    bias = 1'b1;
    for (int k = 0; k < 10000; k++) begin
      if (k % 150 == 0) bias = ~bias;
      if ($urandom_range(0, 499) == 0) do_reset(int'($urandom_range(1, 3)));
      c = ($urandom_range(0, 39) == 0);
      e = 4'($urandom);
      for (int b = 0; b < 4; b++) begin
        u[b] = ($urandom_range(0, 7) == 0) ? ~bias : bias;
        l[b] = ($urandom_range(0, 9) == 0);
        case ($urandom_range(0, 4))
          0:       lv[b*4 +: 4] = 4'd0;
          1:       lv[b*4 +: 4] = 4'd15;
          2:       lv[b*4 +: 4] = 4'd14;
          3:       lv[b*4 +: 4] = 4'd1;
          default: lv[b*4 +: 4] = 4'($urandom);
        endcase
      end
      cycle(c, e, u, l, lv);
    end

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
